qspi_fpu_mailbox: RTL and testbench

Command/mailbox engine on the fabric-clock port (port B) of the dual-port buffer RAM shared with the QSPI slave. It polls a command byte written by the ESP32 host, fetches two 32-bit operands bytewise, hands them to an external floating-point core over a valid/ready handshake, and writes the result and status back into the RAM for the host to read over QSPI.

---
 rtl/qspi_fpu_mailbox.sv | 141 ++++++++++++++
 tb/tb_qspi_fpu_mailbox.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_fpu_mailbox.sv
// Mailbox command engine on RAM port B: polls CMD, fetches operands, drives the FPU
// handshake, then writes the result and status back into the shared RAM.
module qspi_fpu_mailbox #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BASE    = 0,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              wen,
    output logic [1:0]        fpu_op,
    output logic [31:0]       fpu_a,
    output logic [31:0]       fpu_b,
    output logic              fpu_valid,
    input  logic              fpu_ready,
    input  logic              fpu_res_valid,
    input  logic [31:0]       fpu_res,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;

    typedef enum logic [3:0] {
        S_IDLE, S_POLL, S_ACCEPT, S_FETCH, S_ISSUE, S_WAIT_RES,
        S_WR_RES, S_CLR, S_ERR_CLR, S_STAT, S_ERR_STAT
    } state_t;

    state_t      r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_a, r_b, r_res;
    logic [1:0]  r_op;
    logic [3:0]  w_off;
    logic [2:0]  w_idx;

    assign w_idx     = r_cnt[2:0] - 3'd1;
    assign fpu_a     = r_a;
    assign fpu_b     = r_b;
    assign fpu_op    = r_op;
    assign addr      = ADDR_W'(BASE) + ADDR_W'(w_off);

    always_comb begin
        w_next    = r_state;
        w_off     = 4'h0;
        data_out  = 8'h00;
        wen       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fpu_valid = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_POLL;
            S_POLL: begin
                if (!data_in[7])     w_next = S_IDLE;
                else if (data_in[2]) w_next = S_ERR_CLR;
                else                 w_next = S_ACCEPT;
            end
            S_ACCEPT: begin
                w_off    = 4'h1;
                data_out = 8'h01;
                wen      = 1'b1;
                busy     = 1'b1;
                w_next   = S_FETCH;
            end
            S_FETCH: begin
                // Addresses issued on counts 0-7; count 8 only collects the last byte.
                busy  = 1'b1;
                w_off = 4'h4 + {1'b0, r_cnt[2:0]};
                if (r_cnt == CW'(8)) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                fpu_valid = 1'b1;
                if (fpu_ready) w_next = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                busy = 1'b1;
                if (fpu_res_valid)                 w_next = S_WR_RES;
                else if (r_cnt == CW'(TIMEOUT - 1)) w_next = S_ERR_CLR;
            end
            S_WR_RES: begin
                busy     = 1'b1;
                wen      = 1'b1;
                w_off    = 4'hC + {2'b00, r_cnt[1:0]};
                data_out = r_res[{r_cnt[1:0], 3'b000} +: 8];
                if (r_cnt[1:0] == 2'd3) w_next = S_CLR;
            end
            S_CLR: begin
                busy   = 1'b1;
                wen    = 1'b1;
                w_next = S_STAT;
            end
            S_ERR_CLR: begin
                busy   = 1'b1;
                wen    = 1'b1;
                w_next = S_ERR_STAT;
            end
            S_STAT: begin
                w_off    = 4'h1;
                data_out = 8'h80;
                wen      = 1'b1;
                done     = 1'b1;
                w_next   = S_IDLE;
            end
            S_ERR_STAT: begin
                w_off    = 4'h1;
                data_out = 8'hC0;
                wen      = 1'b1;
                done     = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            // One shared counter: restarts on every state change.
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
            if (r_state == S_POLL && w_next == S_ACCEPT)
                r_op <= data_in[1:0];
            if (r_state == S_FETCH && r_cnt != '0) begin
                if (w_idx[2]) r_b[{w_idx[1:0], 3'b000} +: 8] <= data_in;
                else          r_a[{w_idx[1:0], 3'b000} +: 8] <= data_in;
            end
            if (r_state == S_WAIT_RES && fpu_res_valid)
                r_res <= fpu_res;
        end
    end

endmodule

// File: tb/tb_qspi_fpu_mailbox.sv
// Bench for qspi_fpu_mailbox: RAM and FPU models, mailbox scoreboard checked on each done pulse.
module tb_qspi_fpu_mailbox;

    localparam int unsigned AW = 8;
    localparam int unsigned B  = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [7:0]    data_in = 8'h00;
    logic [7:0]    data_out;
    logic          wen;
    logic [1:0]    fpu_op;
    logic [31:0]   fpu_a, fpu_b;
    logic          fpu_valid;
    logic          fpu_ready;
    logic          fpu_res_valid;
    logic [31:0]   fpu_res;
    logic          busy, done;

    always #5 clk = ~clk;

    qspi_fpu_mailbox #(.ADDR_W(AW), .BASE(B), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .data_out(data_out),
        .wen(wen), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_valid(fpu_valid),
        .fpu_ready(fpu_ready), .fpu_res_valid(fpu_res_valid), .fpu_res(fpu_res),
        .busy(busy), .done(done)
    );

    // Shared buffer RAM: DUT port B plus a host write port
    logic [7:0] mem [256];
    logic       h_we;
    logic [7:0] h_addr, h_data;
    always @(posedge clk) begin
        if (wen)  mem[addr]   <= data_out;
        if (h_we) mem[h_addr] <= h_data;
        data_in <= mem[addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return a ^ b;
        endcase
    endfunction

    typedef struct { bit ok; logic [31:0] res; logic [31:0] sent; int lat; } exp_t;
    typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; } req_t;
    exp_t sbq[$];
    req_t rq[$];

    int          stall_left = 0;
    int          lat_cfg    = 1;
    int          n_handled  = 0;
    int          acc_cyc    = 0;
    bit          quiet      = 0;
    int          quiet_wen  = 0;

    // FPU model: programmable stall before ready, result strobe lat_cfg cycles after handshake
    initial begin
        automatic bit          active = 0;
        automatic bit          prev_stall = 0;
        automatic int          resp_cnt = 0;
        automatic logic [31:0] resp_val = '0;
        automatic logic [31:0] s_a = '0, s_b = '0;
        automatic logic [1:0]  s_op = '0;
        automatic req_t        r;
        fpu_ready = 1'b0; fpu_res_valid = 1'b0; fpu_res = '0;
        forever begin
            @(negedge clk);
            fpu_res_valid = 1'b0;
            if (!rst_n) begin
                active = 0; prev_stall = 0; fpu_ready = 1'b0;
            end else begin
                if (active) begin
                    if (resp_cnt <= 1) begin
                        fpu_res_valid = 1'b1; fpu_res = resp_val; active = 0;
                    end else resp_cnt--;
                end
                if (prev_stall) begin
                    chk("hold_valid", fpu_valid, 1);
                    chk("hold_a", fpu_a, s_a);
                    chk("hold_b", fpu_b, s_b);
                    chk("hold_op", fpu_op, s_op);
                end
                prev_stall = 0;
                if (fpu_valid) begin
                    if (stall_left > 0) begin
                        stall_left--; fpu_ready = 1'b0; prev_stall = 1;
                        s_a = fpu_a; s_b = fpu_b; s_op = fpu_op;
                    end else begin
                        fpu_ready = 1'b1;
                        if (rq.size() == 0) chk("req_expected", 0, 1);
                        else begin
                            r = rq.pop_front();
                            chk("req_op", fpu_op, r.op);
                            chk("req_a", fpu_a, r.a);
                            chk("req_b", fpu_b, r.b);
                        end
                        active = 1; resp_cnt = lat_cfg; resp_val = fpu_fn(fpu_op, fpu_a, fpu_b);
                    end
                end else fpu_ready = 1'b0;
            end
        end
    end

    // Monitor: write-address legality, accept timestamp, final mailbox contents on done
    initial begin
        automatic exp_t        e;
        automatic logic [7:0]  off;
        automatic logic [31:0] rmem;
        forever begin
            @(negedge clk);
            if (rst_n && wen) begin
                off = addr - 8'(B);
                chk("wen_addr", (off <= 8'd1) || (off >= 8'd12 && off <= 8'd15), 1);
                if (off == 8'd1 && data_out == 8'h01) acc_cyc = cyc;
                if (quiet) quiet_wen++;
            end
            if (rst_n && done) begin
                if (sbq.size() == 0) chk("done_expected", 0, 1);
                else begin
                    e = sbq.pop_front();
                    if (e.lat >= 0) chk("latency", cyc - acc_cyc, e.lat);
                    @(negedge clk);
                    chk("done_pulse", done, 0);
                    rmem = {mem[B+15], mem[B+14], mem[B+13], mem[B+12]};
                    chk("result", rmem, e.ok ? e.res : e.sent);
                    chk("cmd_clear", mem[B], 0);
                    chk("status", mem[B+1], e.ok ? 8'h80 : 8'hC0);
                end
                n_handled++;
            end
        end
    end

    task automatic host_wr(input int a, input logic [7:0] d);
        h_addr = 8'(a); h_data = d; h_we = 1'b1;
        @(negedge clk);
        h_we = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_addr", addr, B);
        chk("rst_data_out", data_out, 0);
        chk("rst_wen", wen, 0);
        chk("rst_fpu_valid", fpu_valid, 0);
        chk("rst_fpu_op", fpu_op, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_b", fpu_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input int stall, input int lat, input bit mid_reset);
        automatic exp_t        e;
        automatic req_t        r;
        automatic bit          legal;
        automatic int          h, i;
        automatic logic [31:0] sent = $urandom;
        for (int k = 0; k < 4; k++) host_wr(B + 4 + k,  a[8*k +: 8]);
        for (int k = 0; k < 4; k++) host_wr(B + 8 + k,  b[8*k +: 8]);
        for (int k = 0; k < 4; k++) host_wr(B + 12 + k, sent[8*k +: 8]);
        host_wr(B + 1, 8'h00);
        legal  = cmd[7] && (cmd[2:0] < 3'd4);
        e.ok   = legal && (lat <= TO);
        e.res  = fpu_fn(cmd[1:0], a, b);
        e.sent = sent;
        e.lat  = !legal ? -1 : (e.ok ? 16 + stall + lat : 28 + stall);
        if (legal) begin
            r.op = cmd[1:0]; r.a = a; r.b = b;
            rq.push_back(r);
        end
        sbq.push_back(e);
        stall_left = stall;
        lat_cfg    = lat;
        h = n_handled;
        host_wr(B, cmd);
        if (mid_reset) begin
            for (i = 0; i < 20 && !busy; i++) @(negedge clk);
            chk("busy_before_reset", busy, 1);
            repeat (4) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            check_reset_vals();
            rst_n = 1'b1;
        end
        for (i = 0; i < 400 && n_handled == h; i++) @(negedge clk);
        if (n_handled == h) begin
            chk("done_timeout", 0, 1);
            sbq.delete();
            rq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        automatic int busy_hi = 0;
        rst_n = 1'b0;
        h_we = 1'b0; h_addr = '0; h_data = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        run_cmd(8'h80, 32'h3F800000, 32'h40000000, 0, 3, 0);
        run_cmd(8'h85, $urandom, $urandom, 0, 1, 0);
        run_cmd(8'h82, $urandom, $urandom, 10, 2, 0);
        run_cmd(8'h81, $urandom, $urandom, 0, 40, 0);
        run_cmd(8'h83, $urandom, $urandom, 0, 16, 0);
        run_cmd(8'h80, $urandom, $urandom, 2, 17, 0);
        run_cmd(8'h81, $urandom, $urandom, 0, 1, 0);

        host_wr(B, 8'h03);
        quiet = 1; quiet_wen = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        quiet = 0;
        chk("idle_wen", quiet_wen, 0);
        chk("idle_busy", busy_hi, 0);
        chk("idle_cmd", mem[B], 8'h03);
        host_wr(B, 8'h00);

        run_cmd(8'h80, 32'h3F800000, 32'h40000000, 0, 3, 1);

        for (int n = 0; n < 20; n++) begin
            automatic logic [7:0] c = 8'h80 | 8'($urandom_range(0, 7));
            run_cmd(c, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(1, 18), 0);
        end

        chk("sb_empty", sbq.size(), 0);
        chk("req_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
